// File: rtl/excess6_to_bcd_packer_pkg.sv
// Shared constants and state encoding for the Excess-6 to BCD packer.
// Contents: code offset, lowest valid code, FSM state type.
package excess6_to_bcd_packer_pkg;

  localparam logic [3:0] EXCESS6_OFFSET    = 4'd6;
  localparam logic [3:0] EXCESS6_MIN_VALID = 4'd6;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/excess6_digit_decode.sv
// Combinational Excess-6 digit decoder.
// Ports: code (4b in) -> bcd (4b out), valid (1b out, code >= 6).
module excess6_digit_decode
  import excess6_to_bcd_packer_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       valid
);

  assign bcd   = code - EXCESS6_OFFSET;
  assign valid = (code >= EXCESS6_MIN_VALID);

endmodule

// File: rtl/excess6_to_bcd_packer.sv
// Packs a stream of Excess-6 digits into NDIGITS-wide BCD words.
// Ports: clk, rst (sync, active-high); in_valid/in_code/in_last/in_ready
// digit input; out_valid/out_bcd/out_ndig/out_ready word output;
// err_pulse/err_count report invalid codes (count saturates).
module excess6_to_bcd_packer
  import excess6_to_bcd_packer_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int ERRW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           in_code,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [4*NDIGITS-1:0] out_bcd,
  output logic [3:0]           out_ndig,
  input  logic                 out_ready,
  output logic                 err_pulse,
  output logic [ERRW-1:0]      err_count
);

  localparam int         W    = 4 * NDIGITS;
  localparam logic [3:0] FULL = 4'(NDIGITS);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] acc;
  logic [W-1:0] acc_shift;
  logic [3:0]   cnt;
  logic [3:0]   cnt_inc;
  logic [3:0]   bcd;
  logic         code_ok;
  logic         take;
  logic         put;
  logic         close;

  excess6_digit_decode u_dec (
    .code  (in_code),
    .bcd   (bcd),
    .valid (code_ok)
  );

  // A single-digit word has nothing to shift up.
  generate
    if (NDIGITS == 1) begin : g_one
      assign acc_shift = bcd;
    end else begin : g_many
      assign acc_shift = {acc[W-5:0], bcd};
    end
  endgenerate

  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    take       = 1'b0;
    put        = 1'b0;
    close      = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready = 1'b1;
        take     = in_valid;
        if (take) begin
          if (code_ok)
            close = (cnt_inc == FULL) || in_last;
          else
            close = in_last && (cnt != 4'd0);
        end
        if (close)
          state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        put       = out_ready;
        if (put)
          state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= COLLECT;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= take && !code_ok;
      if (take && code_ok) begin
        acc <= acc_shift;
        cnt <= cnt_inc;
      end else if (put) begin
        acc <= '0;
        cnt <= '0;
      end
      if (take && !code_ok && (err_count != '1))
        err_count <= err_count + ERRW'(1);
    end
  end

  assign out_bcd  = (state == HOLD) ? acc : '0;
  assign out_ndig = (state == HOLD) ? cnt : 4'd0;

endmodule
